// File: rtl/keypad_capture.sv
// Debounce timer, 4x4 key decoder and two-digit history for the keypad path.
// Times the scanner's debounce request, then validates and decodes the press.
module keypad_capture #(
   parameter logic [23:0] DEBOUNCE_CYCLES = 24'd240000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  C,
   input  logic [3:0]  R_press,
   input  logic        key_press,
   input  logic        debounce,
   output logic        debounce_done,
   output logic [23:0] bounce_cycle_wait,
   output logic        key_valid,
   output logic [3:0]  key_code,
   output logic [3:0]  digit_new,
   output logic [3:0]  digit_old
);

   typedef enum logic [1:0] {IDLE, COUNT, CHECK, DONE} state_t;

   state_t      state;
   logic [23:0] count;
   logic [3:0]  col_q;
   logic [3:0]  row_q;
   logic        accept;
   logic [3:0]  decoded;

   function automatic logic [1:0] onehot_index(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      case (v)
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   // Key map indexed by {row, column}.
   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] k;
      k = 4'h0;
      case ({r, c})
         4'd0:  k = 4'h1;
         4'd1:  k = 4'h2;
         4'd2:  k = 4'h3;
         4'd3:  k = 4'hA;
         4'd4:  k = 4'h4;
         4'd5:  k = 4'h5;
         4'd6:  k = 4'h6;
         4'd7:  k = 4'hB;
         4'd8:  k = 4'h7;
         4'd9:  k = 4'h8;
         4'd10: k = 4'h9;
         4'd11: k = 4'hC;
         4'd12: k = 4'hE;
         4'd13: k = 4'h0;
         4'd14: k = 4'hF;
         default: k = 4'hD;
      endcase
      return k;
   endfunction

   // The key must still be down at the same position it had when the count began.
   always_comb begin
      accept  = key_press && (C == col_q) && (R_press == row_q) &&
                $onehot(col_q) && $onehot(row_q);
      decoded = key_map(onehot_index(row_q), onehot_index(col_q));
   end

   assign bounce_cycle_wait = DEBOUNCE_CYCLES;
   assign debounce_done     = (state == DONE);

   // NOTE: every register here updates with <= so all reads see pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         count     <= 24'd0;
         col_q     <= 4'd0;
         row_q     <= 4'd0;
         key_valid <= 1'b0;
         key_code  <= 4'd0;
         digit_new <= 4'd0;
         digit_old <= 4'd0;
      end else begin
         key_valid <= 1'b0;
         case (state)
            IDLE: begin
               count <= 24'd0;
               if (debounce && key_press) begin
                  col_q <= C;
                  row_q <= R_press;
                  state <= COUNT;
               end
            end
            COUNT: begin
               if (count == DEBOUNCE_CYCLES - 24'd1) state <= CHECK;
               else                                  count <= count + 24'd1;
            end
            CHECK: begin
               if (accept) begin
                  key_valid <= 1'b1;
                  key_code  <= decoded;
                  digit_new <= decoded;
                  digit_old <= digit_new;
               end
               state <= DONE;
            end
            DONE: begin
               if (!key_press) begin
                  count <= 24'd0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_capture.sv
// Randomized bench for keypad_capture, checked against a press-level model:
// each press is a transaction whose outcome follows from the key map and accept rules.
module tb_keypad_capture;

   localparam logic [23:0] N = 24'd4;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  C;
   logic [3:0]  R_press;
   logic        key_press;
   logic        debounce;
   logic        debounce_done;
   logic [23:0] bounce_cycle_wait;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [3:0]  digit_new;
   logic [3:0]  digit_old;

   keypad_capture #(.DEBOUNCE_CYCLES(N)) dut (
      .clk(clk), .reset(reset), .C(C), .R_press(R_press),
      .key_press(key_press), .debounce(debounce),
      .debounce_done(debounce_done), .bounce_cycle_wait(bounce_cycle_wait),
      .key_valid(key_valid), .key_code(key_code),
      .digit_new(digit_new), .digit_old(digit_old)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   logic [3:0] exp_code = 4'h0;
   logic [3:0] exp_new  = 4'h0;
   logic [3:0] exp_old  = 4'h0;
   int n_pulses = 0;

   always @(posedge clk) if (key_valid) n_pulses++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int bit_pos(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return 0;
   endfunction

   // Keypad layout as printed on the keys, row by row.
   function automatic logic [3:0] key_of(input logic [3:0] c, input logic [3:0] r);
      logic [3:0] layout [16];
      layout = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                 4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
      return layout[bit_pos(r) * 4 + bit_pos(c)];
   endfunction

   task automatic check_outputs(input string tag, input logic kv, input logic dd);
      check({tag, ".key_valid"}, key_valid, kv);
      check({tag, ".debounce_done"}, debounce_done, dd);
      check({tag, ".key_code"}, key_code, exp_code);
      check({tag, ".digit_new"}, digit_new, exp_new);
      check({tag, ".digit_old"}, digit_old, exp_old);
   endtask

   // One debounce request: latch (c,r), scramble inputs while counting, present
   // (c_chk,r_chk,kp_chk) during the check cycle, hold, then release.
   task automatic press(input logic [3:0] c, input logic [3:0] r,
                        input logic [3:0] c_chk, input logic [3:0] r_chk,
                        input logic kp_chk, input int hold);
      logic acc;
      C = c; R_press = r; key_press = 1'b1; debounce = 1'b1;
      tick();
      for (int i = 1; i <= int'(N); i++) begin
         C = 4'($urandom); R_press = 4'($urandom);
         key_press = 1'($urandom); debounce = 1'($urandom);
         check_outputs("count", 1'b0, 1'b0);
         tick();
      end
      C = c_chk; R_press = r_chk; key_press = kp_chk; debounce = 1'b0;
      check_outputs("check", 1'b0, 1'b0);
      tick();
      acc = kp_chk && (c_chk == c) && (r_chk == r) &&
            ($countones(c) == 1) && ($countones(r) == 1);
      if (acc) begin
         exp_old  = exp_new;
         exp_new  = key_of(c, r);
         exp_code = exp_new;
      end
      check_outputs("done", acc, 1'b1);
      if (kp_chk) begin
         for (int i = 0; i < hold; i++) begin
            debounce = 1'($urandom);
            tick();
            check_outputs("held", 1'b0, 1'b1);
         end
      end
      key_press = 1'b0; debounce = 1'b0;
      tick();
      check_outputs("release", 1'b0, 1'b0);
   endtask

   initial begin
      int pulses_before;
      reset = 1'b0; C = 4'd0; R_press = 4'd0; key_press = 1'b0; debounce = 1'b0;
      tick();
      tick();
      check_outputs("reset", 1'b0, 1'b0);
      check("bounce_cycle_wait", bounce_cycle_wait, N);
      reset = 1'b1;
      tick();

      press(4'b0010, 4'b0010, 4'b0010, 4'b0010, 1'b1, 2);
      check("key5.code", key_code, 4'h5);
      press(4'b0001, 4'b0001, 4'b0001, 4'b0001, 1'b1, 1);
      pulses_before = n_pulses;
      press(4'b0100, 4'b0100, 4'b0100, 4'b0100, 1'b1, 50);
      check("held.pulses", n_pulses - pulses_before, 1);
      check("hist.old", digit_old, 4'h1);
      check("hist.new", digit_new, 4'h9);

      press(4'b0001, 4'b0001, 4'b0001, 4'b0010, 1'b1, 3);
      press(4'b0001, 4'b0011, 4'b0001, 4'b0011, 1'b1, 3);

      // A request without key_press must be ignored.
      debounce = 1'b1; key_press = 1'b0; C = 4'b0001; R_press = 4'b0001;
      for (int i = 0; i < int'(N) + 3; i++) begin
         tick();
         check_outputs("no_press", 1'b0, 1'b0);
      end
      debounce = 1'b0;

      for (int k = 0; k < 40; k++) begin
         logic [3:0] c, r, c_chk, r_chk;
         logic kp;
         c = 4'b0001 << $urandom_range(0, 3);
         r = 4'b0001 << $urandom_range(0, 3);
         if ($urandom_range(0, 7) == 0) c = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) r = 4'($urandom_range(0, 15));
         c_chk = c; r_chk = r; kp = 1'b1;
         case ($urandom_range(0, 5))
            1: r_chk = r ^ (4'b0001 << $urandom_range(0, 3));
            2: c_chk = c ^ (4'b0001 << $urandom_range(0, 3));
            3: kp = 1'b0;
            default: ;
         endcase
         press(c, r, c_chk, r_chk, kp, $urandom_range(0, 4));
      end

      // Reset during the third COUNT cycle.
      C = 4'b0001; R_press = 4'b0001; key_press = 1'b1; debounce = 1'b1;
      tick();
      debounce = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      exp_code = 4'h0; exp_new = 4'h0; exp_old = 4'h0;
      check_outputs("rst_mid", 1'b0, 1'b0);
      reset = 1'b1;
      for (int i = 0; i < int'(N) + 4; i++) begin
         tick();
         check_outputs("after_rst", 1'b0, 1'b0);
      end
      key_press = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/keypad_capture.md
# keypad_capture

Debounce timer, key decoder and two-digit history register for the 4x4 keypad path. Sits directly downstream of the column scanner FSM. It accepts the scanner's debounce request together with the driven column and pressed-row snapshot, and times the debounce interval. It then answers with `debounce_done`, validates and decodes the key into a hex code, and emits exactly one `key_valid` pulse per debounced press. A two-digit shift history feeds the dual seven-segment display driver.

## Interface
- `DEBOUNCE_CYCLES`, default 24'd240000: debounce interval in clk cycles (legal range 1 to 2^24-1). Also driven out on `bounce_cycle_wait`.

- `clk`  input  1  system clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-low.
- `C`  input  4  one-hot column currently driven by the scanner.
- `R_press`  input  4  row snapshot from the scanner (one-hot when valid).
- `key_press`  input  1  scanner reports a key down in the active column.
- `debounce`  input  1  scanner requests a debounce interval.
- `debounce_done`  output  1  debounce interval has elapsed; held until the key is released.
- `bounce_cycle_wait`  output  24  constant equal to `DEBOUNCE_CYCLES`, wired to the scanner.
- `key_valid`  output  1  one-cycle pulse: a new key was accepted.
- `key_code`  output  4  hex code of the last accepted key.
- `digit_new`  output  4  most recent accepted key code.
- `digit_old`  output  4  previous accepted key code.

## Operation
- **State machine** (states IDLE, COUNT, CHECK, DONE):
  - **IDLE:** counter is 0.
    - Condition: `debounce` = 1 and `key_press` = 1.
    - Action: latch `C` into col_q and `R_press` into row_q, then go to COUNT.
    - Otherwise stay in IDLE; `debounce` without `key_press` is ignored.
  - **COUNT:** counter increments each cycle.
    - When the counter reaches `DEBOUNCE_CYCLES`-1, go to CHECK.
    - Input changes do not abort the count.
  - **CHECK:** lasts one cycle.
    - The press is accepted when all of these hold: `key_press` = 1, `C` == col_q, `R_press` == row_q, col_q has exactly one bit set, and row_q has exactly one bit set.
    - On accept: `key_code` ← decoded value, `digit_old` ← `digit_new`, `digit_new` ← decoded value, `key_valid` ← 1 for one cycle.
    - On reject: no pulse, and the history is unchanged.
    - Go to DONE in either case.
  - **DONE:** `debounce_done` = 1.
    - When `key_press` = 0, return to IDLE and clear the counter.
    - Otherwise stay in DONE; a held key never produces a second pulse.
- **`debounce_done`:** decoded from state (state == DONE).
- **`key_valid`, `key_code`, `digit_new`, `digit_old`:** registered.
- **Decode:** column index c = 0..3 is the bit position in col_q; row index r = 0..3 is the bit position in row_q. Key map by row (listed c = 0..3):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- **Counter:** 24-bit unsigned with no wrap. It is compared with `DEBOUNCE_CYCLES`-1 only in COUNT.
- **Reset** (`reset` = 0 at a clk edge, in any state, including mid-COUNT):
  - state → IDLE and counter → 0.
  - `key_valid`, `key_code`, `digit_new`, `digit_old` → 0.
  - `debounce_done` → 0.
  - `bounce_cycle_wait` is constant and unaffected.

## Timing
- Request sampled in IDLE at edge t: COUNT occupies cycles t+1 .. t+N, where N = `DEBOUNCE_CYCLES`.
- CHECK occupies cycle t+N+1.
- At edge t+N+2:
  - state becomes DONE, so `debounce_done` rises.
  - if the press is accepted, `key_valid`, `key_code` and the digits update in the same cycle.
- `key_valid` is high for exactly the one cycle starting at t+N+2.
- With `key_press` sampled 0 in DONE at edge u, `debounce_done` falls at u+1, and a new request is accepted at the earliest at the edge after that.
- If `debounce` and `key_press` are both high in the same cycle that DONE exits, they are ignored; a request is only sampled in IDLE.

## Test plan
- **Reset values:** hold `reset` = 0 for 2 cycles → all outputs 0 and `bounce_cycle_wait` = `DEBOUNCE_CYCLES`.
- **Single accepted press** (`DEBOUNCE_CYCLES` = 4):
  - Stimulus: `C` = 0010, `R_press` = 0010, `key_press` = 1, `debounce` = 1 at edge 0.
  - Response: `key_valid` = 1 only during cycle 6; `key_code` = 5, `digit_new` = 5, `digit_old` = 0.
  - `debounce_done` = 1 from cycle 6 until one cycle after `key_press` drops.
- **History:** press "1" (`C` = 0001, `R_press` = 0001), release, then press "9" (`C` = 0100, `R_press` = 0100) → `digit_old` = 1, `digit_new` = 9.
- **Held key:** keep `key_press` = 1 for 50 cycles after acceptance → exactly one `key_valid` pulse.
- **Rejected presses:**
  - `R_press` changes from 0001 to 0010 during COUNT → no `key_valid` and digits unchanged, but `debounce_done` still asserts.
  - A second run with `R_press` = 0011 is also rejected.
- **Reset mid-COUNT:** assert `reset` = 0 during cycle 3 of COUNT → next cycle is IDLE with digits 0; no `key_valid` and no `debounce_done` follow.
